// File: rtl/fab_reset_sequencer.sv
// Fabric reset sequencer feeding CoreResetP FAB_RESET_N: waits for a stable CCC lock,
// then INIT_DONE/MSS_READY, and releases USER_RESET_N after a fixed delay.
module fab_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DEBOUNCE_CYCLES    = 50000,
  parameter int READY_TIMEOUT      = 65535,
  parameter int USER_RST_DELAY     = 16,
  parameter int CNT_W              = 20
) (
  input  logic       CLK_BASE,
  input  logic       POWER_ON_RESET_N,
  input  logic       PB_RESET_N,
  input  logic       FAB_CCC_LOCK,
  input  logic       INIT_DONE,
  input  logic       MSS_READY,
  output logic       FAB_RESET_N,
  output logic       USER_RESET_N,
  output logic [2:0] STATE,
  output logic [7:0] LOCK_LOST_CNT,
  output logic [3:0] TIMEOUT_CNT
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    RELEASE    = 3'd1,
    USER_DELAY = 3'd2,
    RUN        = 3'd3,
    HOLD       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(USER_RST_DELAY - 1);

  // Bit order {pb, ready, init, lock}; the button idles released (high).
  localparam logic [3:0] SYNC_RST = 4'b1000;

  logic [3:0] async_in;
  logic [3:0] sync_out;

  assign async_in = {PB_RESET_N, MSS_READY, INIT_DONE, FAB_CCC_LOCK};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
          chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
        end
      end

      assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic lock_sync;
  logic init_sync;
  logic ready_sync;
  logic pb_sync;

  assign lock_sync  = sync_out[0];
  assign init_sync  = sync_out[1];
  assign ready_sync = sync_out[2];
  assign pb_sync    = sync_out[3];

  // Push-button debounce: any bounce back to the accepted level restarts the count.
  logic             pb_db_reg;
  logic             pb_db_next;
  logic [CNT_W-1:0] db_cnt_reg;
  logic [CNT_W-1:0] db_cnt_next;

  always_comb begin
    pb_db_next  = pb_db_reg;
    db_cnt_next = '0;
    if (pb_sync != pb_db_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        pb_db_next  = pb_sync;
        db_cnt_next = '0;
      end else begin
        db_cnt_next = db_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      pb_db_reg  <= 1'b1;
      db_cnt_reg <= '0;
    end else begin
      pb_db_reg  <= pb_db_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  logic lock_prev_reg;

  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      lock_prev_reg <= 1'b0;
    end else begin
      lock_prev_reg <= lock_sync;
    end
  end

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       lost_reg;
  logic [7:0]       lost_next;
  logic [3:0]       tmo_reg;
  logic [3:0]       tmo_next;
  logic             fab_rst_n_reg;
  logic             fab_rst_n_next;
  logic             user_rst_n_reg;
  logic             user_rst_n_next;
  logic             active;
  logic             lock_fall;
  logic             both_ready;

  assign active     = (state_reg == RELEASE) || (state_reg == USER_DELAY) || (state_reg == RUN);
  assign lock_fall  = lock_prev_reg & ~lock_sync;
  assign both_ready = init_sync & ready_sync;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lost_next  = lost_reg;
    tmo_next   = tmo_reg;

    // Lock loss is logged even when a button press wins the transition.
    if (active && lock_fall && (lost_reg != 8'hFF)) begin
      lost_next = lost_reg + 8'd1;
    end

    if (active && !pb_db_reg) begin
      state_next = HOLD;
      cnt_next   = '0;
    end else if (active && !lock_sync) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (!pb_db_reg) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else if (!lock_sync) begin
            cnt_next = '0;
          end else if (cnt_reg == LOCK_LAST) begin
            state_next = RELEASE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (both_ready) begin
            state_next = USER_DELAY;
            cnt_next   = '0;
          end else if (cnt_reg == TMO_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
            if (tmo_reg != 4'hF) begin
              tmo_next = tmo_reg + 4'd1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        USER_DELAY: begin
          if (cnt_reg == DELAY_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          if (!both_ready) begin
            state_next = RELEASE;
            cnt_next   = '0;
          end
        end
        HOLD: begin
          cnt_next = '0;
          if (pb_db_reg) begin
            state_next = WAIT_LOCK;
          end
        end
        default: begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      endcase
    end

    // Resets are decoded from the next state so they move on the same edge as STATE.
    fab_rst_n_next  = (state_next == RELEASE) || (state_next == USER_DELAY) ||
                      (state_next == RUN);
    user_rst_n_next = (state_next == RUN);
  end

  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      state_reg      <= WAIT_LOCK;
      cnt_reg        <= '0;
      lost_reg       <= '0;
      tmo_reg        <= '0;
      fab_rst_n_reg  <= 1'b0;
      user_rst_n_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      lost_reg       <= lost_next;
      tmo_reg        <= tmo_next;
      fab_rst_n_reg  <= fab_rst_n_next;
      user_rst_n_reg <= user_rst_n_next;
    end
  end

  assign FAB_RESET_N   = fab_rst_n_reg;
  assign USER_RESET_N  = user_rst_n_reg;
  assign STATE         = state_reg;
  assign LOCK_LOST_CNT = lost_reg;
  assign TIMEOUT_CNT   = tmo_reg;

endmodule
